// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-port synchronous memory (one-cycle read
// latency) between requester A (CPU) and requester B (loader/debug).
// Pipeline: arbitrate (cycle N) -> issue on memory bus (N+1) -> return (N+2).
// Optional macro MEM_ARB_B_PRIORITY_EN: port B gets fixed priority instead of
// round-robin.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  port_t             rr_last;
  port_t             rd_port;
  logic              rd_pend;
  logic              elig_a, elig_b;
  logic              win_a, win_b;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  // Arbitration: a port is blanked for one cycle right after its grant.
  always_comb begin
    elig_a = a_req & ~a_gnt;
    elig_b = b_req & ~b_gnt;
    win_a  = 1'b0;
    win_b  = 1'b0;
`ifdef MEM_ARB_B_PRIORITY_EN
    win_b = elig_b;
    win_a = elig_a & ~elig_b;
`else
    if (elig_a && elig_b) begin
      win_a = (rr_last == PORT_B);
      win_b = (rr_last == PORT_A);
    end else begin
      win_a = elig_a;
      win_b = elig_b;
    end
`endif
  end

  // Issue and return stages; address/data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_gnt            <= 1'b0;
      b_gnt            <= 1'b0;
      a_rvalid         <= 1'b0;
      b_rvalid         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      rr_last          <= PORT_B;
      rd_pend          <= 1'b0;
      rd_port          <= PORT_A;
      a_rdata_q        <= '0;
      b_rdata_q        <= '0;
    end else begin
      a_gnt <= win_a;
      b_gnt <= win_b;
      if (win_a || win_b) begin
        mem_address      <= win_a ? a_addr  : b_addr;
        mem_data_in      <= win_a ? a_wdata : b_wdata;
        mem_write_enable <= win_a ? a_we    : b_we;
        rr_last          <= win_a ? PORT_A  : PORT_B;
        rd_port          <= win_a ? PORT_A  : PORT_B;
        rd_pend          <= win_a ? ~a_we   : ~b_we;
      end else begin
        mem_write_enable <= 1'b0;
        rd_pend          <= 1'b0;
      end
      a_rvalid <= rd_pend && (rd_port == PORT_A);
      b_rvalid <= rd_pend && (rd_port == PORT_B);
      // Capture the returned word so rdata holds once rvalid drops.
      if (a_rvalid) a_rdata_q <= mem_data_out;
      if (b_rvalid) b_rdata_q <= mem_data_out;
    end
  end

  // Memory data is only valid in the return cycle, so it is passed straight
  // through then and replaced by the captured copy afterwards.
  assign a_rdata = a_rvalid ? mem_data_out : a_rdata_q;
  assign b_rdata = b_rvalid ? mem_data_out : b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_write_enable;
  logic [DW-1:0] mem_data_out = '0;
  logic [DW-1:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write_enable === 1'b1) mem[mem_address[7:0]] <= mem_data_in;
    mem_data_out <= mem[mem_address[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    tests++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt got a=%b b=%b exp 0 0", a_gnt, b_gnt); end
    tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got a=%b b=%b exp 0 0", a_rvalid, b_rvalid); end
    tests++; if (mem_write_enable !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", mem_write_enable); end
    tests++; if (mem_address !== '0 || mem_data_in !== '0) begin fails++; $display("FAIL reset_bus got addr=%h data=%h exp 0 0", mem_address, mem_data_in); end
    tests++; if (a_rdata !== '0 || b_rdata !== '0) begin fails++; $display("FAIL reset_rdata got a=%h b=%h exp 0 0", a_rdata, b_rdata); end
    rst = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    tick();
    tests++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin fails++; $display("FAIL read_gnt got a=%b b=%b exp 1 0", a_gnt, b_gnt); end
    tests++; if (mem_address !== 32'h10 || mem_write_enable !== 1'b0) begin fails++; $display("FAIL read_bus got addr=%h we=%b exp 10 0", mem_address, mem_write_enable); end
    a_req = 0;
    tick();
    tests++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin fails++; $display("FAIL read_rvalid got a=%b b=%b exp 1 0", a_rvalid, b_rvalid); end
    tests++; if (a_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL read_rdata got %h exp deadbeef", a_rdata); end
    tick();
    tests++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL read_hold got rv=%b data=%h exp 0 deadbeef", a_rvalid, a_rdata); end
  endtask

  task automatic test_write_then_read();
    do_reset();
    b_req = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h12345678;
    tick();
    tests++; if (b_gnt !== 1'b1 || mem_write_enable !== 1'b1) begin fails++; $display("FAIL wr_issue got gnt=%b we=%b exp 1 1", b_gnt, mem_write_enable); end
    tests++; if (mem_address !== 32'h20 || mem_data_in !== 32'h12345678) begin fails++; $display("FAIL wr_bus got addr=%h data=%h exp 20 12345678", mem_address, mem_data_in); end
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 32'h20;
    tick();
    tests++; if (b_rvalid !== 1'b0 || a_gnt !== 1'b1 || mem_write_enable !== 1'b0) begin fails++; $display("FAIL wr_then_rd got b_rv=%b a_gnt=%b we=%b exp 0 1 0", b_rvalid, a_gnt, mem_write_enable); end
    a_req = 0;
    tick();
    tests++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h12345678 || b_rvalid !== 1'b0) begin fails++; $display("FAIL wr_readback got rv=%b data=%h b_rv=%b exp 1 12345678 0", a_rvalid, a_rdata, b_rvalid); end
  endtask

  task automatic test_contention();
    logic exp_a, exp_b;
    logic prev_a, prev_b;
    prev_a = 0; prev_b = 0;
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h1;
    b_req = 1; b_we = 0; b_addr = 32'h2;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin a_req = 0; b_req = 0; end
      tick();
      if (i < 8) begin
`ifdef MEM_ARB_B_PRIORITY_EN
        exp_b = (i % 2 == 0);
`else
        exp_b = (i % 2 == 1);
`endif
        exp_a = !exp_b;
      end else begin
        exp_a = 0; exp_b = 0;
      end
      tests++; if (a_gnt !== exp_a || b_gnt !== exp_b) begin fails++; $display("FAIL contend_gnt cyc %0d got a=%b b=%b exp a=%b b=%b", i, a_gnt, b_gnt, exp_a, exp_b); end
      tests++; if (a_rvalid !== prev_a || b_rvalid !== prev_b) begin fails++; $display("FAIL contend_rvalid cyc %0d got a=%b b=%b exp a=%b b=%b", i, a_rvalid, b_rvalid, prev_a, prev_b); end
      if (prev_a) begin
        tests++; if (a_rdata !== 32'h1111_1111) begin fails++; $display("FAIL contend_a_rdata cyc %0d got %h exp 11111111", i, a_rdata); end
      end
      if (prev_b) begin
        tests++; if (b_rdata !== 32'h2222_2222) begin fails++; $display("FAIL contend_b_rdata cyc %0d got %h exp 22222222", i, b_rdata); end
      end
      prev_a = exp_a; prev_b = exp_b;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h33;
    tick();
    tests++; if (a_gnt !== 1'b1 || mem_address !== 32'h33) begin fails++; $display("FAIL midrst_gnt got gnt=%b addr=%h exp 1 33", a_gnt, mem_address); end
    a_req = 0;
    rst = 1;
    tick();
    tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin fails++; $display("FAIL midrst_rvalid got a=%b b=%b exp 0 0", a_rvalid, b_rvalid); end
    tests++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_write_enable !== 1'b0) begin fails++; $display("FAIL midrst_ctl got a=%b b=%b we=%b exp 0 0 0", a_gnt, b_gnt, mem_write_enable); end
    tests++; if (mem_address !== '0 || mem_data_in !== '0) begin fails++; $display("FAIL midrst_bus got addr=%h data=%h exp 0 0", mem_address, mem_data_in); end
    rst = 0;
    tick();
    tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_gnt !== 1'b0) begin fails++; $display("FAIL midrst_after got rv a=%b b=%b gnt=%b exp 0 0 0", a_rvalid, b_rvalid, a_gnt); end
  endtask

  task automatic test_single_stream();
    logic exp_g, exp_rv;
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g  = (i % 2 == 0);
      exp_rv = (i % 2 == 1);
      tests++; if (a_gnt !== exp_g || mem_write_enable !== 1'b0) begin fails++; $display("FAIL stream_gnt cyc %0d got gnt=%b we=%b exp %b 0", i, a_gnt, mem_write_enable, exp_g); end
      tests++; if (a_rvalid !== exp_rv) begin fails++; $display("FAIL stream_rvalid cyc %0d got %b exp %b", i, a_rvalid, exp_rv); end
      if (exp_rv) begin
        tests++; if (a_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL stream_rdata cyc %0d got %h exp deadbeef", i, a_rdata); end
      end
    end
    a_req = 0;
  endtask

  // Random traffic vs. a transaction-level model: grant rules, reference
  // memory contents and a one-deep return slot.
  task automatic test_random();
    logic [DW-1:0] ref_mem [0:255];
    logic          m_ga, m_gb, m_last_b;
    logic          ea, eb, wa, wb;
    logic          pend_v, pend_b;
    logic [DW-1:0] pend_data, last_a, last_b;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    do_reset();
    for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];
    m_ga = 0; m_gb = 0; m_last_b = 1; pend_v = 0; pend_b = 0;
    pend_data = '0; last_a = '0; last_b = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      ea = a_req && !m_ga;
      eb = b_req && !m_gb;
`ifdef MEM_ARB_B_PRIORITY_EN
      wb = eb;
      wa = ea && !eb;
`else
      if (ea && eb) begin wa = m_last_b; wb = !m_last_b; end
      else begin wa = ea; wb = eb; end
`endif
      tests++; if (a_gnt !== wa || b_gnt !== wb) begin fails++; $display("FAIL rand_gnt cyc %0d got a=%b b=%b exp a=%b b=%b", c, a_gnt, b_gnt, wa, wb); end
      tests++; if (a_rvalid !== (pend_v && !pend_b) || b_rvalid !== (pend_v && pend_b)) begin fails++; $display("FAIL rand_rvalid cyc %0d got a=%b b=%b exp a=%b b=%b", c, a_rvalid, b_rvalid, pend_v && !pend_b, pend_v && pend_b); end
      if (pend_v && !pend_b) last_a = pend_data;
      if (pend_v && pend_b)  last_b = pend_data;
      tests++; if (a_rdata !== last_a || b_rdata !== last_b) begin fails++; $display("FAIL rand_rdata cyc %0d got a=%h b=%h exp a=%h b=%h", c, a_rdata, b_rdata, last_a, last_b); end
      pend_v = 0;
      exp_we = 0;
      if (wa || wb) begin
        exp_we    = wa ? a_we    : b_we;
        exp_addr  = wa ? a_addr  : b_addr;
        exp_wdata = wa ? a_wdata : b_wdata;
        tests++; if (mem_address !== exp_addr || mem_data_in !== exp_wdata) begin fails++; $display("FAIL rand_bus cyc %0d got addr=%h data=%h exp %h %h", c, mem_address, mem_data_in, exp_addr, exp_wdata); end
        if (exp_we) ref_mem[exp_addr[7:0]] = exp_wdata;
        else begin pend_v = 1; pend_b = wb; pend_data = ref_mem[exp_addr[7:0]]; end
        m_last_b = wb;
      end
      tests++; if (mem_write_enable !== exp_we) begin fails++; $display("FAIL rand_we cyc %0d got %b exp %b", c, mem_write_enable, exp_we); end
      m_ga = wa; m_gb = wb;
      if (wa) a_req = 0;
      if (wb) b_req = 0;
      if (!a_req && $urandom_range(0, 2) != 0) begin
        a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = AW'($urandom_range(0, 15)); a_wdata = $urandom;
      end
      if (!b_req && $urandom_range(0, 2) != 0) begin
        b_req = 1; b_we = 1'($urandom_range(0, 1)); b_addr = AW'($urandom_range(0, 15)); b_wdata = $urandom;
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'(k) * 32'h0101_0101;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h01] = 32'h1111_1111;
    mem[8'h02] = 32'h2222_2222;
    idle_inputs();
    rst = 1;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_reset_mid();
    test_single_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
